// File: rtl/mfp_adc_max10_responder_pkg.sv
// Shared constants and types for the MAX10 ADC responder and the core that drives it.
// The ADC_* defaults are the single source both sides take their parameters from.
package mfp_adc_max10_responder_pkg;

   localparam int          ADC_RESP_CONV_CYCLES = 12;
   localparam int          ADC_TEMP_CHANNEL     = 17;
   localparam logic [11:0] ADC_TEMP_CODE        = 12'h7A0;
   localparam int          ADC_MAX_CHANNEL      = 17;

   localparam int ADC_CH_W   = 5;
   localparam int ADC_DATA_W = 12;
   localparam int ADC_SAMP_W = 7;

   typedef struct packed {
      logic [ADC_CH_W-1:0] ch;
      logic                sop;
      logic                eop;
   } adc_cmd_t;

endpackage

// File: rtl/mfp_adc_max10_resp_datagen.sv
// Combinational response-data generator: maps (channel, sample count) to the 12-bit result
// and flags channels above the legal range.
module mfp_adc_max10_resp_datagen
   import mfp_adc_max10_responder_pkg::*;
#(
   parameter int          TEMP_CHANNEL = ADC_TEMP_CHANNEL,
   parameter logic [11:0] TEMP_CODE    = ADC_TEMP_CODE,
   parameter int          MAX_CHANNEL  = ADC_MAX_CHANNEL
)(
   input  logic [ADC_CH_W-1:0]   i_ch,
   input  logic [ADC_SAMP_W-1:0] i_samp,
   output logic [ADC_DATA_W-1:0] o_data,
   output logic                  o_err
);

   // Temperature channel wins over the range check so a fixed code is always returned for it.
   always_comb begin
      o_data = {i_ch, i_samp};
      o_err  = 1'b0;
      if (i_ch == 5'(TEMP_CHANNEL)) begin
         o_data = TEMP_CODE;
         o_err  = 1'b0;
      end else if (i_ch > 5'(MAX_CHANNEL)) begin
         o_data = 12'hFFF;
         o_err  = 1'b1;
      end else begin
         o_data = {i_ch, i_samp};
         o_err  = 1'b0;
      end
   end

endmodule

// File: rtl/mfp_adc_max10_responder.sv
// Avalon-ST command/response stand-in for the MAX10 modular ADC: one active conversion plus
// a one-deep pending slot, fixed conversion latency, deterministic response data.
module mfp_adc_max10_responder
   import mfp_adc_max10_responder_pkg::*;
#(
   parameter int          CONV_CYCLES  = ADC_RESP_CONV_CYCLES,
   parameter int          TEMP_CHANNEL = ADC_TEMP_CHANNEL,
   parameter logic [11:0] TEMP_CODE    = ADC_TEMP_CODE,
   parameter int          MAX_CHANNEL  = ADC_MAX_CHANNEL
)(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ADC_PLL_LOCKED,
   input  logic                  ADC_C_Valid,
   input  logic [ADC_CH_W-1:0]   ADC_C_Channel,
   input  logic                  ADC_C_SOP,
   input  logic                  ADC_C_EOP,
   output logic                  ADC_C_Ready,
   output logic                  ADC_R_Valid,
   output logic [ADC_CH_W-1:0]   ADC_R_Channel,
   output logic [ADC_DATA_W-1:0] ADC_R_Data,
   output logic                  ADC_R_SOP,
   output logic                  ADC_R_EOP,
   output logic                  ADC_BUSY,
   output logic                  ADC_CH_ERR
);

   localparam int CNT_W = $clog2(CONV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   adc_cmd_t              r_act;
   adc_cmd_t              r_pend;
   logic                  r_pend_v;
   logic [ADC_SAMP_W-1:0] r_samp;
   logic                  r_rsp_valid;
   logic [ADC_CH_W-1:0]   r_rsp_ch;
   logic [ADC_DATA_W-1:0] r_rsp_data;
   logic                  r_rsp_sop;
   logic                  r_rsp_eop;
   logic                  r_ch_err;

   logic                  w_ready;
   logic                  w_accept;
   adc_cmd_t              w_cmd;
   logic [ADC_DATA_W-1:0] w_data;
   logic                  w_err;

   assign w_ready  = ADC_PLL_LOCKED & ~r_pend_v;
   assign w_accept = ADC_C_Valid & w_ready;
   assign w_cmd    = '{ch: ADC_C_Channel, sop: ADC_C_SOP, eop: ADC_C_EOP};

   mfp_adc_max10_resp_datagen #(
      .TEMP_CHANNEL (TEMP_CHANNEL),
      .TEMP_CODE    (TEMP_CODE),
      .MAX_CHANNEL  (MAX_CHANNEL)
   ) u_datagen (
      .i_ch   (r_act.ch),
      .i_samp (r_samp),
      .o_data (w_data),
      .o_err  (w_err)
   );

   // Conversion FSM with registered response outputs, pending slot and sample counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_act       <= '0;
         r_pend      <= '0;
         r_pend_v    <= 1'b0;
         r_samp      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_ch    <= '0;
         r_rsp_data  <= '0;
         r_rsp_sop   <= 1'b0;
         r_rsp_eop   <= 1'b0;
         r_ch_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_rsp_valid <= 1'b0;
               if (w_accept) begin
                  r_act   <= w_cmd;
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               r_rsp_valid <= 1'b0;
               if (w_accept) begin
                  r_pend   <= w_cmd;
                  r_pend_v <= 1'b1;
               end
               if (r_cnt == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_ch    <= r_act.ch;
                  r_rsp_data  <= w_data;
                  r_rsp_sop   <= r_act.sop;
                  r_rsp_eop   <= r_act.eop;
                  r_ch_err    <= r_ch_err | w_err;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               // Ready is low whenever the pending slot is full, so promotion and a new accept never collide.
               r_rsp_valid <= 1'b0;
               r_samp      <= r_samp + 7'd1;
               if (r_pend_v) begin
                  r_act    <= r_pend;
                  r_pend_v <= 1'b0;
                  r_cnt    <= CNT_LOAD;
                  r_state  <= S_CONV;
               end else if (w_accept) begin
                  r_act   <= w_cmd;
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_CONV;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign ADC_C_Ready   = w_ready;
   assign ADC_R_Valid   = r_rsp_valid;
   assign ADC_R_Channel = r_rsp_ch;
   assign ADC_R_Data    = r_rsp_data;
   assign ADC_R_SOP     = r_rsp_sop;
   assign ADC_R_EOP     = r_rsp_eop;
   assign ADC_BUSY      = (r_state != S_IDLE) | r_pend_v;
   assign ADC_CH_ERR    = r_ch_err;

endmodule

// File: tb/tb_mfp_adc_max10_responder.sv
// Bench for mfp_adc_max10_responder: directed scenarios plus random traffic, all checked against
// a queue-based timing/data model of the responder.
module tb_mfp_adc_max10_responder;

   localparam int CONV = 12;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        ADC_PLL_LOCKED;
   logic        ADC_C_Valid;
   logic [4:0]  ADC_C_Channel;
   logic        ADC_C_SOP;
   logic        ADC_C_EOP;
   logic        ADC_C_Ready;
   logic        ADC_R_Valid;
   logic [4:0]  ADC_R_Channel;
   logic [11:0] ADC_R_Data;
   logic        ADC_R_SOP;
   logic        ADC_R_EOP;
   logic        ADC_BUSY;
   logic        ADC_CH_ERR;

   always #5 CLK = ~CLK;

   mfp_adc_max10_responder dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .ADC_PLL_LOCKED (ADC_PLL_LOCKED),
      .ADC_C_Valid    (ADC_C_Valid),
      .ADC_C_Channel  (ADC_C_Channel),
      .ADC_C_SOP      (ADC_C_SOP),
      .ADC_C_EOP      (ADC_C_EOP),
      .ADC_C_Ready    (ADC_C_Ready),
      .ADC_R_Valid    (ADC_R_Valid),
      .ADC_R_Channel  (ADC_R_Channel),
      .ADC_R_Data     (ADC_R_Data),
      .ADC_R_SOP      (ADC_R_SOP),
      .ADC_R_EOP      (ADC_R_EOP),
      .ADC_BUSY       (ADC_BUSY),
      .ADC_CH_ERR     (ADC_CH_ERR)
   );

   // Each accepted command: when it was accepted, when its conversion starts, when it responds.
   typedef struct {
      int ch;
      bit sop;
      bit eop;
      int acc;
      int start;
      int resp;
   } cmd_t;

   cmd_t q[$];
   int   e          = 0;
   int   last_resp  = -100;
   int   m_samp     = 0;
   bit   m_err      = 1'b0;
   int   n_checks   = 0;
   int   n_fail     = 0;
   bit   last_accepted;
   int   last_acc;
   int   last_rdata;
   int   last_redge;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   function automatic int exp_data(input int ch, input int samp);
      if (ch == 17) return 32'h7A0;
      if (ch > 17) return 32'hFFF;
      return ch * 128 + samp;
   endfunction

   // Pending slot is occupied from the edge after a queued accept up to its promotion edge.
   function automatic bit pend_full(input int en);
      foreach (q[i]) if (q[i].acc < en && en <= q[i].start) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit busy_exp(input int ee);
      foreach (q[i]) if (q[i].acc <= ee && ee <= q[i].resp) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step();
      bit   rdy;
      bit   v;
      bit   rst;
      cmd_t c;
      #1;
      rst = RESET;
      rdy = ADC_PLL_LOCKED && !pend_full(e + 1);
      if (!rst) check_eq("c_ready", ADC_C_Ready, rdy);
      v = ADC_C_Valid;
      c.ch  = ADC_C_Channel;
      c.sop = ADC_C_SOP;
      c.eop = ADC_C_EOP;
      @(posedge CLK);
      e++;
      last_accepted = 1'b0;
      if (rst) begin
         q.delete();
         last_resp = -100;
         m_samp    = 0;
         m_err     = 1'b0;
      end else if (v && rdy) begin
         c.acc   = e;
         c.start = (e > last_resp + 1) ? e : last_resp + 1;
         c.resp  = c.start + CONV;
         last_resp = c.resp;
         q.push_back(c);
         last_accepted = 1'b1;
         last_acc      = e;
      end
      #1;
      check_eq("busy", ADC_BUSY, busy_exp(e));
      if (q.size() > 0 && q[0].resp == e) begin
         check_eq("r_valid", ADC_R_Valid, 1'b1);
         check_eq("r_channel", ADC_R_Channel, q[0].ch);
         check_eq("r_data", ADC_R_Data, exp_data(q[0].ch, m_samp));
         check_eq("r_sop", ADC_R_SOP, q[0].sop);
         check_eq("r_eop", ADC_R_EOP, q[0].eop);
         if (q[0].ch > 17) m_err = 1'b1;
         m_samp     = (m_samp + 1) % 128;
         last_rdata = ADC_R_Data;
         last_redge = e;
         void'(q.pop_front());
      end else begin
         check_eq("r_valid", ADC_R_Valid, 1'b0);
      end
      check_eq("ch_err", ADC_CH_ERR, m_err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input int ch, input bit sop, input bit eop);
      bit got = 1'b0;
      ADC_C_Valid   = 1'b1;
      ADC_C_Channel = 5'(ch);
      ADC_C_SOP     = sop;
      ADC_C_EOP     = eop;
      for (int i = 0; i < 100; i++) begin
         step();
         if (last_accepted) begin
            got = 1'b1;
            break;
         end
      end
      ADC_C_Valid = 1'b0;
      check_eq("send_accept", got, 1'b1);
   endtask

   initial begin
      int k;
      RESET          = 1'b1;
      ADC_PLL_LOCKED = 1'b1;
      ADC_C_Valid    = 1'b0;
      ADC_C_Channel  = 5'd0;
      ADC_C_SOP      = 1'b0;
      ADC_C_EOP      = 1'b0;
      idle(3);
      RESET = 1'b0;
      idle(2);

      // Single command: latency and data.
      send(1, 1'b1, 1'b1);
      k = last_acc;
      idle(14);
      check_eq("t1_latency", last_redge - k, CONV);
      check_eq("t1_data", last_rdata, 32'h080);

      // Held-valid three-command sequence.
      send(3, 1'b1, 1'b0);
      send(4, 1'b0, 1'b0);
      send(5, 1'b0, 1'b1);
      idle(40);
      check_eq("t2_last_data", last_rdata, 32'h283);

      // Temperature channel and illegal channel.
      send(17, 1'b1, 1'b1);
      idle(14);
      check_eq("t3_temp", last_rdata, 32'h7A0);
      send(20, 1'b1, 1'b1);
      idle(14);
      check_eq("t3_illegal", last_rdata, 32'hFFF);
      idle(5);
      check_eq("t3_err_sticky", ADC_CH_ERR, 1'b1);

      // PLL unlocked with a command waiting, then lock.
      ADC_PLL_LOCKED = 1'b0;
      ADC_C_Valid    = 1'b1;
      ADC_C_Channel  = 5'd2;
      ADC_C_SOP      = 1'b1;
      ADC_C_EOP      = 1'b1;
      idle(50);
      ADC_PLL_LOCKED = 1'b1;
      step();
      check_eq("t4_accept_on_lock", last_accepted, 1'b1);
      ADC_C_Valid = 1'b0;
      idle(14);

      // Many singles so the sample counter wraps.
      for (int i = 0; i < 130; i++) begin
         send($urandom_range(0, 16), 1'b1, 1'b1);
         idle(13);
      end

      // Reset mid-conversion with the pending slot full.
      send(6, 1'b1, 1'b0);
      send(7, 1'b0, 1'b1);
      idle(5);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      #1;
      check_eq("t6_ready", ADC_C_Ready, 1'b1);
      idle(20);
      check_eq("t6_busy", ADC_BUSY, 1'b0);
      send(1, 1'b1, 1'b1);
      idle(14);
      check_eq("t6_samp_zero", last_rdata, 32'h080);

      // Random traffic, including lock drops and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         ADC_PLL_LOCKED = ($urandom_range(0, 9) != 0);
         ADC_C_Valid    = $urandom_range(0, 1);
         ADC_C_Channel  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                                      : 5'($urandom_range(0, 17));
         ADC_C_SOP      = $urandom_range(0, 1);
         ADC_C_EOP      = $urandom_range(0, 1);
         RESET          = ($urandom_range(0, 299) == 0);
         step();
      end
      RESET       = 1'b0;
      ADC_C_Valid = 1'b0;
      idle(30);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
